// File: rtl/bus_cycle_arbiter_if.sv
// Bundles the fetch/LSU request ports and the external bus side of
// bus_cycle_arbiter. The arbiter uses the slave view; requesters and memory use the master view.
interface bus_cycle_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic [WIDTH-1:0] if_rdata;
    logic             if_ack;
    logic             if_err;
    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic [WIDTH-1:0] d_rdata;
    logic             d_ack;
    logic             d_err;
    logic [WIDTH-1:0] ADDR;
    logic [WIDTH-1:0] wdata_out;
    logic [WIDTH-1:0] mem_rdata;
    logic             stall_;
    logic             busint;
    logic             dtr_;
    logic [2:0]       t_state;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, stall_,
        output if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
        output ADDR, wdata_out, busint, dtr_, t_state
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, stall_,
        input  if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
        input  ADDR, wdata_out, busint, dtr_, t_state
    );
endinterface

// File: rtl/bus_cycle_arbiter.sv
// Shares the external bus between instruction fetch and load/store, running
// T1..T4 bus cycles with wait states, timeout, and a bounded D burst.
module bus_cycle_arbiter #(
    parameter int WIDTH       = 32,
    parameter int MAX_D_BURST = 4,
    parameter int WAIT_LIMIT  = 15
) (
    input logic               clk,
    input logic               rst,
    bus_cycle_arbiter_if.slave bus
);
    localparam int DCW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
    localparam int WCW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_e;

    state_e           state_q, state_d;
    logic             own_d_q, own_d_d;   // 1 = load/store owns the current cycle
    logic             err_q, err_d;
    logic             dtr_q, dtr_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] irdata_q, irdata_d;
    logic [WIDTH-1:0] drdata_q, drdata_d;
    logic             arb_pt;
    logic             d_wins;

    assign d_wins = bus.d_req && (!bus.if_req || dcnt_q != DCW'(MAX_D_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            own_d_q  <= 1'b0;
            err_q    <= 1'b0;
            dtr_q    <= 1'b1;
            dcnt_q   <= '0;
            wcnt_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            own_d_q  <= own_d_d;
            err_q    <= err_d;
            dtr_q    <= dtr_d;
            dcnt_q   <= dcnt_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        own_d_d  = own_d_q;
        err_d    = err_q;
        dtr_d    = dtr_q;
        dcnt_d   = dcnt_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        arb_pt   = 1'b0;

        case (state_q)
            S_IDLE: arb_pt = 1'b1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (bus.stall_) begin
                    if (dtr_q) begin
                        if (own_d_q) drdata_d = bus.mem_rdata;
                        else         irdata_d = bus.mem_rdata;
                    end
                    state_d = S_T4;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                    if (WAIT_LIMIT != 0 && wcnt_q == WCW'(WAIT_LIMIT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_T4;
                    end
                end
            end
            S_T4: begin
                state_d = S_IDLE;
                arb_pt  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (arb_pt) begin
            if (!bus.if_req) dcnt_d = '0;
            if (d_wins) begin
                own_d_d = 1'b1;
                addr_d  = bus.d_addr;
                dtr_d   = ~bus.d_we;
                if (bus.d_we) wdata_d = bus.d_wdata;
                if (bus.if_req && dcnt_q != DCW'(MAX_D_BURST)) dcnt_d = dcnt_q + DCW'(1);
            end else if (bus.if_req) begin
                own_d_d = 1'b0;
                addr_d  = bus.if_addr;
                dtr_d   = 1'b1;
                dcnt_d  = '0;
            end
            if (d_wins || bus.if_req) begin
                state_d = S_T1;
                err_d   = 1'b0;
                wcnt_d  = '0;
            end
        end
    end

    // IDLE and T4 share 111 so the strobe decoder drops rd_/wr_ in T4.
    always_comb begin
        case (state_q)
            S_T1:    bus.t_state = 3'b000;
            S_T2:    bus.t_state = 3'b001;
            S_T3:    bus.t_state = 3'b010;
            default: bus.t_state = 3'b111;
        endcase
    end

    assign bus.busint    = (state_q != S_IDLE);
    assign bus.dtr_      = dtr_q;
    assign bus.ADDR      = addr_q;
    assign bus.wdata_out = wdata_q;
    assign bus.if_rdata  = irdata_q;
    assign bus.d_rdata   = drdata_q;
    assign bus.if_ack    = (state_q == S_T4) && !own_d_q && !err_q;
    assign bus.if_err    = (state_q == S_T4) && !own_d_q &&  err_q;
    assign bus.d_ack     = (state_q == S_T4) &&  own_d_q && !err_q;
    assign bus.d_err     = (state_q == S_T4) &&  own_d_q &&  err_q;
endmodule
